mul_seq32: RTL and testbench

Multi-cycle 32×32→64 multiplier sequencer for the MULT/MULTU path beside the ALU. It time-shares a single `cla_adder32` instance, the same carry-lookahead adder the ALU uses. It drives that adder through operand conditioning, 32 shift-add steps and result conditioning. The CPU stalls on `busy` and latches `prod_hi`/`prod_lo` on `done`.

---
 rtl/mul_seq32.sv | 193 +++++++++++++++++++
 tb/tb_mul_seq32.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq32.sv
// Sequential 32x32->64 multiplier (MULT/MULTU) that time-shares one carry-lookahead adder.
// Signed operands are converted to magnitudes, multiplied by shift-add, then the sign is applied.

module cla_adder32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    logic [31:0] g, p, c;
    logic [7:0]  gg, gp;
    logic [8:0]  gc;

    always_comb begin
        g = a & b;
        p = a ^ b;
        gg = '0;
        gp = '1;
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 4; j++) begin
                gg[k] = g[4*k+j] | (p[4*k+j] & gg[k]);
                gp[k] = gp[k] & p[4*k+j];
            end
        end
        // Group carries resolve by lookahead; bits inside a nibble take their group carry-in.
        gc = '0;
        gc[0] = cin;
        for (int k = 0; k < 8; k++) begin
            gc[k+1] = gg[k] | (gp[k] & gc[k]);
        end
        c = '0;
        for (int k = 0; k < 8; k++) begin
            c[4*k] = gc[k];
            for (int j = 1; j < 4; j++) begin
                c[4*k+j] = g[4*k+j-1] | (p[4*k+j-1] & c[4*k+j-1]);
            end
        end
        sum  = p ^ c;
        cout = gc[8];
    end
endmodule

module mul_seq32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] prod_hi,
    output logic [31:0] prod_lo
);
    typedef enum logic [2:0] {
        StIdle, StFixA, StFixB, StRun, StFixLo, StFixHi, StDone
    } state_e;

    state_e      state;
    logic [31:0] mc, hi, lo;
    logic [4:0]  cnt, cnt_inc;
    logic        neg, cy, sgn;
    logic [31:0] add_a, add_b, add_s;
    logic        add_ci, add_co;
    logic        inc_c;

    cla_adder32 u_add (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_ci),
        .sum  (add_s),
        .cout (add_co)
    );

    // Adder operand steering: negation is ~x + 1, pass-through is x + 0.
    always_comb begin
        add_a  = hi;
        add_b  = '0;
        add_ci = 1'b0;
        case (state)
            StFixA: begin
                add_a  = mc[31] ? ~mc : mc;
                add_ci = mc[31];
            end
            StFixB: begin
                add_a  = lo[31] ? ~lo : lo;
                add_ci = lo[31];
            end
            StRun: begin
                add_a = hi;
                add_b = lo[0] ? mc : '0;
            end
            StFixLo: begin
                add_a  = neg ? ~lo : lo;
                add_ci = neg;
            end
            StFixHi: begin
                add_a  = neg ? ~hi : hi;
                add_ci = neg & cy;
            end
            default: begin
                add_a  = hi;
                add_b  = '0;
                add_ci = 1'b0;
            end
        endcase
    end

    // Step counter increments without touching the shared adder.
    always_comb begin
        inc_c = 1'b1;
        cnt_inc = '0;
        for (int i = 0; i < 5; i++) begin
            cnt_inc[i] = cnt[i] ^ inc_c;
            inc_c      = inc_c & cnt[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= StIdle;
            mc    <= '0;
            hi    <= '0;
            lo    <= '0;
            cnt   <= '0;
            neg   <= 1'b0;
            cy    <= 1'b0;
            sgn   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle, StDone: begin
                    if (start) begin
                        mc    <= a;
                        lo    <= b;
                        hi    <= '0;
                        cnt   <= '0;
                        neg   <= is_signed & (a[31] ^ b[31]);
                        sgn   <= is_signed;
                        state <= is_signed ? StFixA : StRun;
                        busy  <= 1'b1;
                    end else begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end
                end
                StFixA: begin
                    mc    <= add_s;
                    state <= StFixB;
                end
                StFixB: begin
                    lo    <= add_s;
                    state <= StRun;
                end
                StRun: begin
                    hi  <= {add_co, add_s[31:1]};
                    lo  <= {add_s[0], lo[31:1]};
                    cnt <= cnt_inc;
                    if (cnt == 5'd31) begin
                        if (sgn) begin
                            state <= StFixLo;
                        end else begin
                            state <= StDone;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                StFixLo: begin
                    lo    <= add_s;
                    cy    <= add_co;
                    state <= StFixHi;
                end
                StFixHi: begin
                    hi    <= add_s;
                    state <= StDone;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign prod_hi = hi;
    assign prod_lo = lo;
endmodule

// File: tb/tb_mul_seq32.sv
// Bench for mul_seq32: cycle-level reference model checked every cycle, plus directed
// vectors with hand-computed products and latencies.

module tb_mul_seq32;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done;
    logic [31:0] prod_hi, prod_lo;

    int tests = 0;
    int fails = 0;

    mul_seq32 dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .prod_hi   (prod_hi),
        .prod_lo   (prod_lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                            input logic s);
        logic signed [63:0] sx, sy;
        logic [63:0] ux, uy;
        if (s) begin
            sx = {{32{x[31]}}, x};
            sy = {{32{y[31]}}, y};
            return sx * sy;
        end
        ux = {32'b0, x};
        uy = {32'b0, y};
        return ux * uy;
    endfunction

    // Reference model: tracks only "cycles since accepted start" and the expected product.
    logic        chk_en = 1'b0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic        m_pv = 1'b0;
    logic [63:0] m_prod = '0;
    logic [63:0] m_pend = '0;
    logic        m_act = 1'b0;
    int          m_k = 0;
    int          m_lat = 0;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_busy = 1'b0;
                m_done = 1'b0;
                m_prod = '0;
                m_pv   = 1'b1;
                m_act  = 1'b0;
                chk_en = 1'b1;
            end else if (chk_en) begin
                if (start && !m_busy) begin
                    m_act  = 1'b1;
                    m_k    = 0;
                    m_lat  = is_signed ? 37 : 33;
                    m_pend = ref_mul(a, b, is_signed);
                    m_pv   = 1'b0;
                end
                if (m_act) begin
                    m_k++;
                    m_busy = (m_k < m_lat);
                    m_done = (m_k == m_lat);
                    if (m_k == m_lat) begin
                        m_act  = 1'b0;
                        m_prod = m_pend;
                        m_pv   = 1'b1;
                    end
                end else begin
                    m_busy = 1'b0;
                    m_done = 1'b0;
                end
            end
            @(negedge clk);
            if (chk_en) begin
                chk("busy", {63'b0, busy}, {63'b0, m_busy});
                chk("done", {63'b0, done}, {63'b0, m_done});
                if (m_pv) chk("product", {prod_hi, prod_lo}, m_prod);
            end
        end
    end

    // Launch one operation from the current (idle or done) cycle and wait for its done.
    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic s,
                          input logic use_lit, input logic [63:0] lit, input string name);
        int n;
        start = 1'b1;
        a = x;
        b = y;
        is_signed = s;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while (n < 60) begin
            @(negedge clk);
            n++;
            if (done) break;
        end
        chk({name, " latency"}, 64'(n), s ? 64'd37 : 64'd33);
        if (use_lit) chk({name, " value"}, {prod_hi, prod_lo}, lit);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("idle product", {prod_hi, prod_lo}, 64'h0);
        chk("idle busy", {63'b0, busy}, 64'h0);

        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 64'hFFFFFFFE_00000001, "umax");
        @(posedge clk); #1;
        run_op(32'h80000000, 32'h00000001, 1'b1, 1'b1, 64'hFFFFFFFF_80000000, "min_x_1");
        @(posedge clk); #1;
        run_op(32'h80000000, 32'h80000000, 1'b1, 1'b1, 64'h40000000_00000000, "min_x_min");
        @(posedge clk); #1;
        run_op(32'hFFFFFFFD, 32'h00000007, 1'b1, 1'b1, 64'hFFFFFFFF_FFFFFFEB, "m3_x_7");
        @(posedge clk); #1;
        run_op(32'h00000000, 32'hFFFFFFFB, 1'b1, 1'b1, 64'h0, "0_x_m5");

        // start while busy must be ignored
        @(posedge clk); #1;
        start = 1'b1; a = 32'd5; b = 32'd7; is_signed = 1'b0;
        @(posedge clk); #1;
        a = 32'd1000; b = 32'd1000; is_signed = 1'b1;
        repeat (3) @(posedge clk);
        #1 start = 1'b0;
        begin
            int n;
            n = 3;
            while (n < 60) begin
                @(negedge clk);
                n++;
                if (done) break;
            end
            chk("ignore latency", 64'(n), 64'd33);
            chk("ignore value", {prod_hi, prod_lo}, 64'd35);
        end
        // back-to-back from the done cycle: signed then unsigned
        run_op(32'hFFFFFFFE, 32'h00000003, 1'b1, 1'b1, 64'hFFFFFFFF_FFFFFFFA, "b2b_s");
        run_op(32'h00010000, 32'h00010000, 1'b0, 1'b1, 64'h00000001_00000000, "b2b_u");

        // reset in the middle of RUN
        @(posedge clk); #1;
        start = 1'b1; a = 32'hDEADBEEF; b = 32'h12345678; is_signed = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("post-reset busy", {63'b0, busy}, 64'h0);
        chk("post-reset product", {prod_hi, prod_lo}, 64'h0);
        run_op(32'd123456789, 32'd987654321, 1'b0, 1'b1, 64'h01B13114_FBFF5385, "after_rst");

        // random operands; odd iterations launch back-to-back from the done cycle
        for (int i = 0; i < 1000; i++) begin
            logic [31:0] x, y;
            logic s;
            x = $urandom;
            y = $urandom;
            s = 1'($urandom_range(0, 1));
            if (i[0] == 1'b0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            run_op(x, y, s, 1'b1, ref_mul(x, y, s), "random");
        end
        repeat (3) @(posedge clk);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
